// File: rtl/eq_arb_pkg.sv
// Shared encodings for the arbitrated 4-state equality comparator:
// compare opcodes, 2-bit result code and FSM states.
package eq_arb_pkg;

    typedef enum logic [1:0] {
        OpEq     = 2'b00,
        OpNe     = 2'b01,
        OpCaseEq = 2'b10,
        OpCaseNe = 2'b11
    } cmp_op_e;

    typedef enum logic [1:0] {
        ResZero = 2'b00,
        ResOne  = 2'b01,
        ResX    = 2'b10
    } cmp_res_e;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StResp
    } state_e;

    // 0 <-> 1, X stays X.
    function automatic cmp_res_e res_invert(input cmp_res_e r);
        case (r)
            ResZero: return ResOne;
            ResOne:  return ResZero;
            default: return ResX;
        endcase
    endfunction

endpackage

// File: rtl/eq4_cmp.sv
// Combinational 4-state compare of two value/xz operand pairs of equal width.
// Supports logical (==, !=) and case (===, !==) equality.
module eq4_cmp
    import eq_arb_pkg::*;
#(
    parameter int unsigned WA = 16
) (
    input  logic [WA-1:0] a_val_i,
    input  logic [WA-1:0] a_xz_i,
    input  logic [WA-1:0] b_val_i,
    input  logic [WA-1:0] b_xz_i,
    input  cmp_op_e       op_i,
    output cmp_res_e      result_o
);

    logic [WA-1:0] known_both;
    logic          diff_known;
    logic          any_xz;
    logic          case_eq;
    cmp_res_e      eq_res;

    always_comb begin
        known_both = ~a_xz_i & ~b_xz_i;
        diff_known = |((a_val_i ^ b_val_i) & known_both);
        any_xz     = |(a_xz_i | b_xz_i);
        // A known mismatch dominates any unknown bit.
        if (diff_known) begin
            eq_res = ResZero;
        end else if (any_xz) begin
            eq_res = ResX;
        end else begin
            eq_res = ResOne;
        end
        case_eq = (a_xz_i == b_xz_i) && (((a_val_i ^ b_val_i) & ~a_xz_i) == '0);
    end

    always_comb begin
        result_o = ResZero;
        unique case (op_i)
            OpEq:     result_o = eq_res;
            OpNe:     result_o = res_invert(eq_res);
            OpCaseEq: result_o = case_eq ? ResOne : ResZero;
            OpCaseNe: result_o = case_eq ? ResZero : ResOne;
        endcase
    end

endmodule

// File: rtl/eq_compare_arbiter.sv
// Round-robin arbiter in front of a shared 4-state comparator; one compare in flight,
// result held on a valid/ready response port.
module eq_compare_arbiter
    import eq_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WA    = 16,
    parameter int unsigned WB    = 8,
    localparam int unsigned IdW  = $clog2(N_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_REQ-1:0]    req_valid_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic [N_REQ*WA-1:0] req_a_val_i,
    input  logic [N_REQ*WA-1:0] req_a_xz_i,
    input  logic [N_REQ*WB-1:0] req_b_val_i,
    input  logic [N_REQ*WB-1:0] req_b_xz_i,
    input  logic [N_REQ-1:0]    req_signed_i,
    input  logic [N_REQ*2-1:0]  req_op_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [IdW-1:0]      rsp_id_o,
    output logic [1:0]          rsp_result_o,
    output logic                busy_o
);

    state_e         state_q, state_d;
    logic [IdW-1:0] ptr_q;
    logic [IdW-1:0] cur_id_q;
    logic [WA-1:0]  a_val_q, a_xz_q, b_val_q, b_xz_q;
    cmp_op_e        op_q;
    logic [IdW-1:0] rsp_id_q;
    cmp_res_e       rsp_result_q;

    logic           gnt_found;
    logic [IdW-1:0] gnt_idx;
    logic [IdW-1:0] cand_idx;
    logic           grant;
    logic [WA-1:0]  sel_a_val, sel_a_xz;
    logic [WB-1:0]  sel_b_val, sel_b_xz;
    logic           sel_signed;
    logic [1:0]     sel_op;
    logic [WA-1:0]  b_ext_val, b_ext_xz;
    cmp_res_e       cmp_res;

    // Search starts at the pointer and wraps modulo N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand_idx  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_idx = IdW'((32'(ptr_q) + i) % N_REQ);
            if (!gnt_found && req_valid_i[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
        grant = rst_ni && gnt_found &&
                ((state_q == StIdle) || ((state_q == StResp) && rsp_ready_i));
        for (int unsigned i = 0; i < N_REQ; i++) begin
            req_ready_o[i] = grant && (gnt_idx == IdW'(i));
        end
    end

    always_comb begin
        sel_a_val  = '0;
        sel_a_xz   = '0;
        sel_b_val  = '0;
        sel_b_xz   = '0;
        sel_signed = 1'b0;
        sel_op     = 2'b00;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IdW'(i)) begin
                sel_a_val  = req_a_val_i[i*WA +: WA];
                sel_a_xz   = req_a_xz_i[i*WA +: WA];
                sel_b_val  = req_b_val_i[i*WB +: WB];
                sel_b_xz   = req_b_xz_i[i*WB +: WB];
                sel_signed = req_signed_i[i];
                sel_op     = req_op_i[i*2 +: 2];
            end
        end
        // Signed operands replicate both the MSB value bit and its unknown flag.
        for (int unsigned i = 0; i < WA; i++) begin
            if (i < WB) begin
                b_ext_val[i] = sel_b_val[i];
                b_ext_xz[i]  = sel_b_xz[i];
            end else begin
                b_ext_val[i] = sel_signed & sel_b_val[WB-1];
                b_ext_xz[i]  = sel_signed & sel_b_xz[WB-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StCmp;
            StCmp:   state_d = StResp;
            StResp:  if (rsp_ready_i) state_d = grant ? StCmp : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            cur_id_q     <= '0;
            a_val_q      <= '0;
            a_xz_q       <= '0;
            b_val_q      <= '0;
            b_xz_q       <= '0;
            op_q         <= OpEq;
            rsp_id_q     <= '0;
            rsp_result_q <= ResZero;
        end else begin
            state_q <= state_d;
            if (grant) begin
                ptr_q    <= (gnt_idx == IdW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                cur_id_q <= gnt_idx;
                a_val_q  <= sel_a_val;
                a_xz_q   <= sel_a_xz;
                b_val_q  <= b_ext_val;
                b_xz_q   <= b_ext_xz;
                op_q     <= cmp_op_e'(sel_op);
            end
            if (state_q == StCmp) begin
                rsp_id_q     <= cur_id_q;
                rsp_result_q <= cmp_res;
            end
        end
    end

    eq4_cmp #(
        .WA(WA)
    ) u_cmp (
        .a_val_i  (a_val_q),
        .a_xz_i   (a_xz_q),
        .b_val_i  (b_val_q),
        .b_xz_i   (b_xz_q),
        .op_i     (op_q),
        .result_o (cmp_res)
    );

    assign rsp_valid_o  = (state_q == StResp);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_eq_compare_arbiter.sv
// Directed self-checking bench for eq_compare_arbiter (N_REQ=4, WA=16, WB=8).
module tb_eq_compare_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] a_val = '0, a_xz = '0;
    logic [31:0] b_val = '0, b_xz = '0;
    logic [3:0]  sgn = '0;
    logic [7:0]  op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [1:0]  rsp_result;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          id;
        logic [15:0] av, ax;
        logic [7:0]  bv, bx;
        bit          sg;
        logic [1:0]  op;
        logic [1:0]  exp;
    } vec_t;

    always #5 clk = ~clk;

    eq_compare_arbiter #(
        .N_REQ(4),
        .WA(16),
        .WB(8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_val_i  (a_val),
        .req_a_xz_i   (a_xz),
        .req_b_val_i  (b_val),
        .req_b_xz_i   (b_xz),
        .req_signed_i (sgn),
        .req_op_i     (op),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .busy_o       (busy)
    );

    task automatic set_req(input int id, input logic [15:0] av, input logic [15:0] ax,
                           input logic [7:0] bv, input logic [7:0] bx, input bit sg,
                           input logic [1:0] o);
        a_val[id*16 +: 16] = av;
        a_xz[id*16 +: 16]  = ax;
        b_val[id*8 +: 8]   = bv;
        b_xz[id*8 +: 8]    = bx;
        sgn[id]            = sg;
        op[id*2 +: 2]      = o;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Issues one request from idle and returns what the DUT did; lat counts edges from grant.
    task automatic run_one(input vec_t v, output logic [3:0] gnt, output logic [1:0] rid,
                           output logic [1:0] res, output int lat);
        set_req(v.id, v.av, v.ax, v.bv, v.bx, v.sg, v.op);
        req_valid[v.id] = 1'b1;
        @(negedge clk);
        gnt = req_ready;
        @(posedge clk);
        #1 req_valid[v.id] = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk);
            #1 lat++;
        end
        rid = rsp_id;
        res = rsp_result;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        rst_n = 1'b0;
        #2;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid_busy: got %b/%b expected 0/0", rsp_valid, busy);
        end
        checks++;
        if (rsp_id !== 2'd0 || rsp_result !== 2'b00) begin
            failures++;
            $display("FAIL reset_rsp: got id=%0d res=%b expected id=0 res=00", rsp_id, rsp_result);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
        end
        req_valid = 4'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name, input vec_t tbl[]);
        logic [3:0] gnt;
        logic [1:0] rid, res;
        int         lat;
        foreach (tbl[k]) begin
            run_one(tbl[k], gnt, rid, res, lat);
            checks++;
            if (gnt !== 4'(1 << tbl[k].id)) begin
                failures++;
                $display("FAIL %s[%0d] grant: got %b expected %b", name, k, gnt,
                         4'(1 << tbl[k].id));
            end
            checks++;
            if (lat !== 2) begin
                failures++;
                $display("FAIL %s[%0d] latency: got %0d expected 2", name, k, lat);
            end
            checks++;
            if (rid !== 2'(tbl[k].id)) begin
                failures++;
                $display("FAIL %s[%0d] rsp_id: got %0d expected %0d", name, k, rid, tbl[k].id);
            end
            checks++;
            if (res !== tbl[k].exp) begin
                failures++;
                $display("FAIL %s[%0d] result: got %b expected %b", name, k, res, tbl[k].exp);
            end
        end
    endtask

    task automatic test_logical_eq();
        vec_t tbl[] = '{
            '{0, 16'd10, 16'h0, 8'd10, 8'h0, 1'b0, 2'b00, 2'b01},
            '{0, 16'd10, 16'h0, 8'd20, 8'h0, 1'b0, 2'b00, 2'b00},
            '{0, 16'd10, 16'h0, 8'd20, 8'h0, 1'b0, 2'b01, 2'b01},
            '{0, 16'd10, 16'h0, 8'd10, 8'h0, 1'b0, 2'b01, 2'b00}
        };
        run_table("logical_eq", tbl);
    endtask

    task automatic test_xz();
        vec_t tbl[] = '{
            '{1, 16'h0000, 16'hFFFF, 8'd10, 8'h00, 1'b0, 2'b00, 2'b10},
            '{1, 16'h0000, 16'hFFFF, 8'd10, 8'h00, 1'b0, 2'b01, 2'b10},
            '{1, 16'h0000, 16'hFFFF, 8'h00, 8'hFF, 1'b1, 2'b10, 2'b01},
            '{1, 16'h0000, 16'hFFFF, 8'h00, 8'hFF, 1'b1, 2'b11, 2'b00},
            '{1, 16'h0000, 16'hFFFF, 8'h00, 8'hFF, 1'b0, 2'b10, 2'b00},
            '{2, 16'h0004, 16'h0001, 8'h02, 8'h00, 1'b0, 2'b00, 2'b00},
            '{3, 16'h0001, 16'h0001, 8'h00, 8'h01, 1'b0, 2'b10, 2'b01}
        };
        run_table("xz", tbl);
    endtask

    task automatic test_extension();
        vec_t tbl[] = '{
            '{0, 16'h0001, 16'h0, 8'hFF, 8'h0, 1'b0, 2'b00, 2'b00},
            '{0, 16'hFFFF, 16'h0, 8'hFF, 8'h0, 1'b1, 2'b00, 2'b01},
            '{2, 16'hFFFF, 16'h0, 8'hFF, 8'h0, 1'b0, 2'b00, 2'b00},
            '{3, 16'h00FF, 16'h0, 8'hFF, 8'h0, 1'b0, 2'b10, 2'b01}
        };
        run_table("extension", tbl);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 16'(i), 16'h0, 8'(i), 8'h0, 1'b0, 2'b00);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_rdy = (k % 2 == 0) ? 4'(1 << ((k / 2) % 4)) : 4'b0000;
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rr_grant cycle %0d: got %b expected %b", k, req_ready, exp_rdy);
            end
            if (k >= 2 && k % 2 == 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((k / 2 - 1) % 4)) begin
                    failures++;
                    $display("FAIL rr_rsp cycle %0d: got v=%b id=%0d expected v=1 id=%0d",
                             k, rsp_valid, rsp_id, (k / 2 - 1) % 4);
                end
            end
        end
        @(posedge clk);
        #1 req_valid = 4'h0;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back_stall();
        apply_reset();
        set_req(0, 16'd10, 16'h0, 8'd10, 8'h0, 1'b0, 2'b00);
        set_req(2, 16'd5, 16'h0, 8'd6, 8'h0, 1'b0, 2'b00);
        req_valid = 4'b0101;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL stall_first_grant: got %b expected 0001", req_ready);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 2'b01 ||
                req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL stall_hold cycle %0d: got v=%b id=%0d res=%b rdy=%b expected 1/0/01/0000",
                         k, rsp_valid, rsp_id, rsp_result, req_ready);
            end
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL stall_b2b_grant: got %b expected 0100", req_ready);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_b2b_cmp: got v=%b busy=%b expected 0/1", rsp_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 2'b00) begin
            failures++;
            $display("FAIL stall_b2b_rsp: got v=%b id=%0d res=%b expected 1/2/00",
                     rsp_valid, rsp_id, rsp_result);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_cmp();
        set_req(1, 16'd7, 16'h0, 8'd7, 8'h0, 1'b0, 2'b00);
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL midrst_grant: got %b expected 0010", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0000 ||
            rsp_id !== 2'd0 || rsp_result !== 2'b00) begin
            failures++;
            $display("FAIL midrst_outputs: got busy=%b v=%b rdy=%b id=%0d res=%b expected all 0",
                     busy, rsp_valid, req_ready, rsp_id, rsp_result);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midrst_no_rsp cycle %0d: got v=%b busy=%b expected 0/0",
                         k, rsp_valid, busy);
            end
        end
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_ptr_restart: got %b expected 0001", req_ready);
        end
        req_valid = 4'h0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_logical_eq();
        test_xz();
        test_extension();
        test_round_robin();
        test_back_to_back_stall();
        test_reset_mid_cmp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
